// File: rtl/lut_line_sched.sv
// lut_line_sched: dual-channel (left/right) LUT line prefetch scheduler.
// Issues one line-sized read at a time on a shared LUT read port.
// Channels are arbitrated round-robin. Each channel is paced by line credits
// so that its downstream LUT FIFO never holds more than FIFO_LINES lines.
// Optional feature macro: LUT_SCHED_STALL_CNT_EN adds a saturating stall_cnt
// output that counts cycles with rd_req_valid && !rd_req_ready.
module lut_line_sched #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned FIFO_LINES = 2,
  parameter logic [31:0] LUT_BASE_L = 32'h0000_0000,
  parameter logic [31:0] LUT_BASE_R = 32'h0010_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_en,
  input  logic        fsync_l,
  input  logic        fsync_r,
  input  logic        line_done_l,
  input  logic        line_done_r,
  output logic        rd_req_valid,
  input  logic        rd_req_ready,
  output logic [31:0] rd_req_addr,
  output logic [15:0] rd_req_len,
  output logic        rd_req_ch,
  output logic        busy_l,
  output logic        busy_r,
  output logic        frame_done_l,
  output logic        frame_done_r,
  output logic [1:0]  err
`ifdef LUT_SCHED_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int ISS_W = $clog2(IMG_HEIGHT + 1);

  typedef enum logic {IDLE, RUN} ch_state_t;

  // Index 0 = left, index 1 = right throughout.
  ch_state_t        state       [2];
  logic [ISS_W-1:0] issued      [2];
  logic [3:0]       outstanding [2];
  logic [1:0]       frame_done;

  logic [1:0]  fsync;
  logic [1:0]  line_done;
  logic [1:0]  accept;
  logic [1:0]  eligible;
  logic [1:0]  arm;
  logic [1:0]  dec_ok;
  logic        rr_next;   // channel preferred when both are eligible
  logic        grant_ch;
  logic [31:0] grant_addr;

  assign fsync     = {fsync_r, fsync_l};
  assign line_done = {line_done_r, line_done_l};

  assign busy_l       = (state[0] == RUN);
  assign busy_r       = (state[1] == RUN);
  assign frame_done_l = frame_done[0];
  assign frame_done_r = frame_done[1];

  // Per-channel handshake, credit and arming conditions.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    accept   = '0;
    eligible = '0;
    arm      = '0;
    dec_ok   = '0;
    for (int c = 0; c < 2; c++) begin
      accept[c]   = rd_req_valid && rd_req_ready && (rd_req_ch == 1'(c));
      eligible[c] = (state[c] == RUN) && (issued[c] < ISS_W'(IMG_HEIGHT))
                    && (outstanding[c] < 4'(FIFO_LINES));
      arm[c]      = (state[c] == IDLE) && fsync[c] && frame_en;
      dec_ok[c]   = line_done[c] && (outstanding[c] != 4'd0);
    end
  end

  // Round-robin grant and the line start address of the granted channel.
  always_comb begin
    grant_ch   = (eligible == 2'b11) ? rr_next : eligible[1];
    grant_addr = (grant_ch ? LUT_BASE_R : LUT_BASE_L)
                 + 32'(issued[grant_ch]) * 32'(IMG_WIDTH * 4);
  end

  // Channel FSMs, line counters, frame_done pulses and sticky errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        state[c]       <= IDLE;
        issued[c]      <= '0;
        outstanding[c] <= '0;
      end
      frame_done <= '0;
      err        <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
      frame_done <= '0;
      for (int c = 0; c < 2; c++) begin
        case (state[c])
          IDLE: begin
            if (arm[c]) begin
              state[c]  <= RUN;
              issued[c] <= '0;
            end
          end
          RUN: begin
            if (fsync[c]) err[0] <= 1'b1;
            if (issued[c] == ISS_W'(IMG_HEIGHT) && outstanding[c] == 4'd0) begin
              state[c]      <= IDLE;
              frame_done[c] <= 1'b1;
            end
          end
          default: state[c] <= IDLE;
        endcase
        if (line_done[c] && outstanding[c] == 4'd0) err[1] <= 1'b1;
        if (accept[c]) issued[c] <= issued[c] + 1'b1;
        outstanding[c] <= outstanding[c] + {3'b000, accept[c]} - {3'b000, dec_ok[c]};
      end
    end
  end

  // Request register: loads only while idle, holds stable until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_req_valid <= 1'b0;
      rd_req_addr  <= '0;
      rd_req_len   <= '0;
      rd_req_ch    <= 1'b0;
      rr_next      <= 1'b0;
    end else if (rd_req_valid) begin
      if (rd_req_ready) begin
        rd_req_valid <= 1'b0;
        rr_next      <= ~rd_req_ch;
      end
    end else if (|eligible) begin
      rd_req_valid <= 1'b1;
      rd_req_addr  <= grant_addr;
      rd_req_len   <= 16'(IMG_WIDTH);
      rd_req_ch    <= grant_ch;
    end
  end

`ifdef LUT_SCHED_STALL_CNT_EN
  // Saturating count of back-pressured request cycles, restarted by each new frame.
  always_ff @(posedge clk) begin
    if (rst || (|arm)) begin
      stall_cnt <= '0;
    end else if (rd_req_valid && !rd_req_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lut_line_sched.sv
// Self-checking bench for lut_line_sched (IMG_HEIGHT=4, IMG_WIDTH=640, FIFO_LINES=2).
// Combines a directed vector table, hand-written multi-cycle sequences and a
// randomized run compared cycle by cycle against a behavioural model.
module tb_lut_line_sched;

  localparam int          W      = 640;
  localparam int          H      = 4;
  localparam int          F      = 2;
  localparam logic [31:0] BASE_L = 32'h0000_0000;
  localparam logic [31:0] BASE_R = 32'h0010_0000;
  localparam logic [31:0] LSTEP  = 32'(W * 4);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_en = 1'b0;
  logic        fsync_l = 1'b0, fsync_r = 1'b0;
  logic        line_done_l = 1'b0, line_done_r = 1'b0;
  logic        rd_req_ready = 1'b0;
  logic        rd_req_valid;
  logic [31:0] rd_req_addr;
  logic [15:0] rd_req_len;
  logic        rd_req_ch;
  logic        busy_l, busy_r, frame_done_l, frame_done_r;
  logic [1:0]  err;
`ifdef LUT_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  lut_line_sched #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_LINES(F),
    .LUT_BASE_L(BASE_L), .LUT_BASE_R(BASE_R)
  ) dut (
    .clk(clk), .rst(rst), .frame_en(frame_en),
    .fsync_l(fsync_l), .fsync_r(fsync_r),
    .line_done_l(line_done_l), .line_done_r(line_done_r),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len), .rd_req_ch(rd_req_ch),
    .busy_l(busy_l), .busy_r(busy_r),
    .frame_done_l(frame_done_l), .frame_done_r(frame_done_r),
    .err(err)
`ifdef LUT_SCHED_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- behavioural reference model ----------------
  // Frame-level view: a channel is running, has handed out m_iss lines and
  // holds m_out lines in its FIFO. One request slot is shared by both.
  int          m_run [2];
  int          m_iss [2];
  int          m_out [2];
  int          m_fd  [2];
  logic [1:0]  m_err;
  int          m_pref;
  int          m_valid;
  int          m_ch;
  logic [31:0] m_addr;
  int          m_stall;

  task automatic model_edge(input logic r, input logic [1:0] fs, input logic [1:0] ld,
                            input logic fe, input logic rdy);
    int acc_ch;
    int can [2];
    int pick;
    int armed;
    int pre_valid;
    if (r) begin
      for (int c = 0; c < 2; c++) begin
        m_run[c] = 0; m_iss[c] = 0; m_out[c] = 0; m_fd[c] = 0;
      end
      m_err = 2'b00; m_pref = 0; m_valid = 0; m_ch = 0; m_addr = '0; m_stall = 0;
      return;
    end
    pre_valid = m_valid;
    for (int c = 0; c < 2; c++)
      can[c] = (m_run[c] != 0 && m_iss[c] < H && m_out[c] < F) ? 1 : 0;
    acc_ch = -1;
    if (m_valid != 0) begin
      if (rdy) begin
        acc_ch  = m_ch;
        m_valid = 0;
        m_pref  = 1 - m_ch;
      end
    end else if (can[0] + can[1] > 0) begin
      if (can[0] != 0 && can[1] != 0) pick = m_pref;
      else pick = can[1];
      m_valid = 1;
      m_ch    = pick;
      m_addr  = (pick == 1 ? BASE_R : BASE_L) + 32'(m_iss[pick]) * LSTEP;
    end
    armed = 0;
    for (int c = 0; c < 2; c++) begin
      m_fd[c] = 0;
      if (m_run[c] == 0) begin
        if (fs[c] && fe) begin m_run[c] = 1; m_iss[c] = 0; armed = 1; end
      end else begin
        if (fs[c]) m_err[0] = 1'b1;
        if (m_iss[c] == H && m_out[c] == 0) begin m_run[c] = 0; m_fd[c] = 1; end
      end
      if (ld[c] && m_out[c] == 0) m_err[1] = 1'b1;
      if (ld[c] && m_out[c] > 0) m_out[c]--;
      if (acc_ch == c) begin m_out[c]++; m_iss[c]++; end
    end
    if (armed != 0) m_stall = 0;
    else if (pre_valid != 0 && !rdy && m_stall < 65535) m_stall++;
  endtask

  // One clock: inputs sampled at the edge, outputs observed 1 time unit later.
  task automatic tick();
    logic [1:0] fs, ld;
    logic fe, rdy, r;
    fs  = {fsync_r, fsync_l};
    ld  = {line_done_r, line_done_l};
    fe  = frame_en;
    rdy = rd_req_ready;
    r   = rst;
    @(posedge clk);
    model_edge(r, fs, ld, fe, rdy);
    #1;
    fsync_l = 1'b0; fsync_r = 1'b0; line_done_l = 1'b0; line_done_r = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; frame_en = 1'b0; rd_req_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20; i++) begin
      if (rd_req_valid) break;
      tick();
    end
    check({name, "_valid_seen"}, rd_req_valid, 1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        fs_l;
    logic        ld_l;
    logic        ld_r;
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic        exp_busy_l;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vecs [12];

  task automatic run_table();
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 2'b00}; // arm left
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,    1'b1, 2'b00}; // line 0 request
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 2'b00}; // accepted
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hA00,  1'b1, 2'b00}; // line 1 request
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 2'b00}; // accepted, FIFO full
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 2'b00}; // no credit
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 2'b01}; // fsync while RUN
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    1'b1, 2'b11}; // underflow on idle right
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 2'b11}; // one credit back
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h1400, 1'b1, 2'b11}; // line 2 request
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 2'b11}; // accepted
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 2'b11}; // no credit again
    do_reset();
    frame_en = 1'b1; rd_req_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      fsync_l = vecs[i].fs_l; line_done_l = vecs[i].ld_l; line_done_r = vecs[i].ld_r;
      tick();
      check($sformatf("tbl%0d_valid", i), rd_req_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check($sformatf("tbl%0d_addr", i), rd_req_addr, vecs[i].exp_addr);
      check($sformatf("tbl%0d_busy_l", i), busy_l, vecs[i].exp_busy_l);
      check($sformatf("tbl%0d_busy_r", i), busy_r, 0);
      check($sformatf("tbl%0d_err", i), err, vecs[i].exp_err);
      check($sformatf("tbl%0d_fd_l", i), frame_done_l, 0);
    end
  endtask

  // Full left frame with line_done 3 clk after each accept.
  task automatic run_full_frame();
    logic [31:0] exp_a [4];
    int due [$];
    int acc, lds, fd_cnt, fd_lds;
    exp_a[0] = 32'h0; exp_a[1] = 32'hA00; exp_a[2] = 32'h1400; exp_a[3] = 32'h1E00;
    acc = 0; lds = 0; fd_cnt = 0; fd_lds = -1;
    do_reset();
    frame_en = 1'b1; rd_req_ready = 1'b1; fsync_l = 1'b1;
    tick();
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (rd_req_valid && rd_req_ready) begin
        if (acc < 4) begin
          check($sformatf("s1_addr%0d", acc), rd_req_addr, exp_a[acc]);
          check($sformatf("s1_len%0d", acc), rd_req_len, 640);
          check($sformatf("s1_ch%0d", acc), rd_req_ch, 0);
        end
        acc++;
        due.push_back(cyc + 3);
      end
      if (due.size() > 0 && due[0] == cyc) begin
        line_done_l = 1'b1;
        void'(due.pop_front());
        lds++;
      end
      tick();
      if (frame_done_l) begin fd_cnt++; fd_lds = lds; end
    end
    check("s1_req_count", acc, 4);
    check("s1_frame_done_count", fd_cnt, 1);
    check("s1_fd_after_4th_ld", fd_lds, 4);
    check("s1_busy_l_end", busy_l, 0);
    check("s1_err", err, 0);
  endtask

  // Both channels armed together: grants alternate 0,1,0,1,...
  task automatic run_dual();
    int due_c [$];
    int due_ch [$];
    int seq [$];
    int fdl, fdr, nl, nr;
    fdl = 0; fdr = 0; nl = 0; nr = 0;
    do_reset();
    frame_en = 1'b1; rd_req_ready = 1'b1; fsync_l = 1'b1; fsync_r = 1'b1;
    tick();
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (rd_req_valid && rd_req_ready) begin
        if (rd_req_ch) begin
          check($sformatf("s3_raddr%0d", nr), rd_req_addr, BASE_R + 32'(nr) * LSTEP);
          nr++;
        end else begin
          check($sformatf("s3_laddr%0d", nl), rd_req_addr, BASE_L + 32'(nl) * LSTEP);
          nl++;
        end
        seq.push_back(int'(rd_req_ch));
        due_c.push_back(cyc + 1);
        due_ch.push_back(int'(rd_req_ch));
      end
      if (due_c.size() > 0 && due_c[0] == cyc) begin
        if (due_ch[0] == 1) line_done_r = 1'b1; else line_done_l = 1'b1;
        void'(due_c.pop_front());
        void'(due_ch.pop_front());
      end
      tick();
      if (frame_done_l) fdl++;
      if (frame_done_r) fdr++;
    end
    check("s3_req_count", seq.size(), 8);
    for (int i = 0; i < seq.size() && i < 8; i++)
      check($sformatf("s3_ch_seq%0d", i), seq[i], i % 2);
    check("s3_fd_l", fdl, 1);
    check("s3_fd_r", fdr, 1);
  endtask

  // Back-pressure: request fields hold for 5 stalled cycles, one accept only.
  task automatic run_stall();
    logic [31:0] a0;
    logic [15:0] l0;
    logic        c0;
    do_reset();
    frame_en = 1'b1; rd_req_ready = 1'b0; fsync_l = 1'b1;
    tick();
    wait_valid("s4");
    a0 = rd_req_addr; l0 = rd_req_len; c0 = rd_req_ch;
    check("s4_addr0", a0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("s4_hold_valid%0d", i), rd_req_valid, 1);
      check($sformatf("s4_hold_addr%0d", i), rd_req_addr, a0);
      check($sformatf("s4_hold_len%0d", i), rd_req_len, l0);
      check($sformatf("s4_hold_ch%0d", i), rd_req_ch, c0);
    end
`ifdef LUT_SCHED_STALL_CNT_EN
    check("s4_stall_cnt", stall_cnt, 5);
`endif
    rd_req_ready = 1'b1;
    tick();
    check("s4_valid_drop", rd_req_valid, 0);
    wait_valid("s4_next");
    check("s4_next_addr", rd_req_addr, 32'hA00);
  endtask

  // Reset while a request is pending; restart begins at the base address.
  task automatic run_mid_reset();
    do_reset();
    frame_en = 1'b1; rd_req_ready = 1'b0; fsync_l = 1'b1;
    tick();
    wait_valid("s6");
    fsync_l = 1'b1;
    tick();
    check("s6_err_before", err, 2'b01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s6_valid", rd_req_valid, 0);
    check("s6_busy_l", busy_l, 0);
    check("s6_err", err, 0);
    check("s6_fd_l", frame_done_l, 0);
    tick();
    check("s6_fd_l_after", frame_done_l, 0);
    rd_req_ready = 1'b1; fsync_l = 1'b1;
    tick();
    check("s6_rearm_busy", busy_l, 1);
    wait_valid("s6_restart");
    check("s6_restart_addr", rd_req_addr, BASE_L);
  endtask

  // Randomized traffic compared against the model every cycle.
  task automatic run_random();
    logic [7:0] got, exp;
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      frame_en     = ($urandom_range(9) != 0);
      rd_req_ready = ($urandom_range(9) < 7);
      fsync_l      = ($urandom_range(29) == 0);
      fsync_r      = ($urandom_range(29) == 0);
      line_done_l  = (m_out[0] > 0 && $urandom_range(3) == 0) || ($urandom_range(199) == 0);
      line_done_r  = (m_out[1] > 0 && $urandom_range(3) == 0) || ($urandom_range(199) == 0);
      tick();
      got = {rd_req_valid, rd_req_valid & rd_req_ch, busy_r, busy_l,
             frame_done_r, frame_done_l, err};
      exp = {m_valid[0], m_valid[0] & m_ch[0], m_run[1][0], m_run[0][0],
             m_fd[1][0], m_fd[0][0], m_err};
      check($sformatf("rnd%0d_status", cyc), got, exp);
      if (m_valid != 0) begin
        check($sformatf("rnd%0d_addr", cyc), rd_req_addr, m_addr);
        check($sformatf("rnd%0d_len", cyc), rd_req_len, 640);
      end
`ifdef LUT_SCHED_STALL_CNT_EN
      check($sformatf("rnd%0d_stall", cyc), stall_cnt, m_stall);
`endif
    end
  endtask

  initial begin
    do_reset();
    check("rst_valid", rd_req_valid, 0);
    check("rst_addr", rd_req_addr, 0);
    check("rst_len", rd_req_len, 0);
    check("rst_ch", rd_req_ch, 0);
    check("rst_busy", {busy_r, busy_l}, 0);
    check("rst_fd", {frame_done_r, frame_done_l}, 0);
    check("rst_err", err, 0);
    run_table();
    run_full_frame();
    run_dual();
    run_stall();
    run_mid_reset();
    run_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lut_line_sched.md
Name: lut_line_sched

Overview:
Dual-channel (left/right camera) LUT prefetch scheduler for the rectification pipeline. It issues one line-sized LUT read request at a time to a single shared LUT memory read port, arbitrating round-robin between channels. Request flow per channel is paced by a line-credit scheme so each channel's downstream LUT FIFO, which feeds a fetch stage, never overflows. It also sequences frame start and end from each channel's frame sync.

Parameters:
IMG_WIDTH, 640, LUT words (32-bit) per line; also the request length
IMG_HEIGHT, 480, lines per frame
FIFO_LINES, 2, line capacity of each channel's LUT FIFO (max outstanding lines per channel), 1..15
LUT_BASE_L, 32'h0000_0000, byte base address of left LUT
LUT_BASE_R, 32'h0010_0000, byte base address of right LUT

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
frame_en  in  1  allows new frames to arm
fsync_l  in  1  left frame start, 1-cycle pulse
fsync_r  in  1  right frame start, 1-cycle pulse
line_done_l  in  1  left FIFO drained one full LUT line, 1-cycle pulse
line_done_r  in  1  right FIFO drained one full LUT line, 1-cycle pulse
rd_req_valid  out  1  read request valid
rd_req_ready  in  1  memory port accepts request
rd_req_addr  out  32  byte address of line start
rd_req_len  out  16  words to read (= IMG_WIDTH)
rd_req_ch  out  1  0 = left, 1 = right
busy_l  out  1  left channel in RUN
busy_r  out  1  right channel in RUN
frame_done_l  out  1  1-cycle pulse at end of left frame
frame_done_r  out  1  1-cycle pulse at end of right frame
err  out  2  sticky; bit0 = fsync while RUN, bit1 = line_done underflow

Behaviour:
- Reset: all outputs 0; both channels IDLE; counters 0; round-robin pointer = left.
- Per-channel FSM: IDLE -> RUN when fsync && frame_en. RUN -> IDLE when issued == IMG_HEIGHT && outstanding == 0. On that transition, frame_done pulses for 1 cycle.
- fsync in RUN: ignored and sets err[0]. fsync with frame_en = 0: ignored, no error. Deasserting frame_en does not abort running frames.
- Counters per channel:
  - issued: 0..IMG_HEIGHT.
  - outstanding: 0..FIFO_LINES.
  - Accept (rd_req_valid && rd_req_ready for that channel): issued += 1, outstanding += 1.
  - line_done: outstanding -= 1.
  - Accept and line_done in the same cycle: net outstanding unchanged.
  - line_done with outstanding == 0: no decrement; sets err[1].
- Eligibility: RUN && issued < IMG_HEIGHT && outstanding < FIFO_LINES.
- Request register:
  - Loaded on an edge where no request is pending (rd_req_valid == 0) and at least one channel is eligible.
  - Both eligible: grant the channel other than the last granted. Pointer updates on accept.
  - Address = base + issued*IMG_WIDTH*4, computed as a 32-bit product with no wrap check. len = IMG_WIDTH.
- Handshake: addr, len and ch are held stable while valid && !ready. valid drops the cycle after accept. Minimum 1 idle cycle between requests, so the peak rate is 1 request per 2 clk.
- Latency: fsync sampled at edge k -> busy high after k. rd_req_valid high after edge k+1.
- rst mid-operation: pending request dropped at that edge. No frame_done is generated. err is cleared.
- err is cleared only by rst.

Optional Feature:
LUT_SCHED_STALL_CNT_EN
- Defined: adds output stall_cnt [15:0], a saturating count (stops at 16'hFFFF) of cycles with rd_req_valid && !rd_req_ready. It clears on rst and on any fsync that arms a channel.
- Undefined: the port and logic are absent. All other behaviour is identical.

Test Plan:
(All scenarios use IMG_HEIGHT = 4, IMG_WIDTH = 640, FIFO_LINES = 2.)
1. fsync_l with ready tied high and line_done_l 3 clk after each accept -> exactly 4 requests with addr 0x0, 0xA00, 0x1400, 0x1E00, len 640, ch 0. frame_done_l pulses once after the 4th line_done_l. busy_l then falls.
2. No line_done_l after fsync_l -> exactly 2 requests issued, then valid stays 0. A single line_done_l -> 1 more request.
3. fsync_l and fsync_r in the same cycle, ready high, line_done pulses prompt -> ch sequence 0,1,0,1,... Right addresses start at 0x0010_0000.
4. ready held low for 5 clk -> addr, len and ch are stable for all 5 cycles. Only 1 accept is counted. Under LUT_SCHED_STALL_CNT_EN, stall_cnt = 5.
5. fsync_l during RUN -> err = 2'b01 and the frame continues unaffected. line_done_r while the right channel is IDLE -> err = 2'b11.
6. rst asserted while valid && !ready mid-frame -> the next cycle has valid = 0, busy = 0, err = 0. A new fsync restarts from addr = base.
